// File: rtl/fmul_round.sv
`default_nettype none
// ============================================================================
// Module      : fmul_round
// Description : Normalise-and-round stage that follows the binary32
//               significand multiplier. It takes the sign, the raw biased
//               exponents and the 48-bit significand product. It produces a
//               packed binary32 result with overflow and underflow flags.
//               Two pipeline registers (A: normalise, B: round/classify)
//               with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   in_valid   in   1   upstream offers an operand set
//   in_ready   out  1   stage accepts the offered operand set
//   in_s       in   1   result sign
//   in_e1/e2   in   8   raw biased operand exponents
//   in_prod    in   48  24x24 significand product, hidden bits included
//   in_zero    in   1   an operand is zero/denormal
//   out_valid  out  1   y/ovf/unf hold a result
//   out_ready  in   1   downstream consumes the result
//   y          out  32  packed result {sign, exp, frac}
//   ovf        out  1   result overflowed to infinity
//   unf        out  1   result underflowed, flushed to zero
// ============================================================================
module fmul_round (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_s,
  input  logic [7:0]  in_e1,
  input  logic [7:0]  in_e2,
  input  logic [47:0] in_prod,
  input  logic        in_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        unf
);

  localparam logic [9:0] c_BIAS    = 10'd127;
  localparam logic [9:0] c_EXP_MAX = 10'd255;
  localparam logic [9:0] c_EXP_MIN = 10'd0;

  // --------------------------------------------------------------------------
  // Handshake / stall control
  // --------------------------------------------------------------------------
  logic r_a_valid;
  logic r_b_valid;
  logic w_b_free;
  logic w_a_adv;
  logic w_in_xfer;

  // B can take a new item when it is empty or is being drained this cycle.
  assign w_b_free  = ~r_b_valid | out_ready;
  assign w_a_adv   = r_a_valid & w_b_free;
  // Combinational path from out_ready: keeps full throughput under flow.
  assign in_ready  = ~r_a_valid | w_b_free;
  assign w_in_xfer = in_valid & in_ready;

  // --------------------------------------------------------------------------
  // Stage A: exponent sum and normalisation
  // --------------------------------------------------------------------------
  logic [9:0]  w_exp_sum;
  logic [9:0]  w_a_exp_nxt;
  logic [22:0] w_a_frac_nxt;
  logic        w_a_guard_nxt;
  logic        w_a_sticky_nxt;
  logic        w_a_inf_nxt;

  // Two's-complement 10-bit arithmetic; the range -127..384 fits comfortably.
  assign w_exp_sum = {2'b00, in_e1} + {2'b00, in_e2} - c_BIAS;

  always_comb begin
    w_a_exp_nxt    = w_exp_sum;
    w_a_frac_nxt   = in_prod[45:23];
    w_a_guard_nxt  = in_prod[22];
    w_a_sticky_nxt = |in_prod[21:0];
    if (in_prod[47]) begin
      // Product in [2,4): shift right by one and bump the exponent.
      w_a_exp_nxt    = w_exp_sum + 10'd1;
      w_a_frac_nxt   = in_prod[46:24];
      w_a_guard_nxt  = in_prod[23];
      w_a_sticky_nxt = |in_prod[22:0];
    end
  end

  assign w_a_inf_nxt = (in_e1 == 8'hFF) | (in_e2 == 8'hFF);

  logic        r_a_s;
  logic        r_a_zero;
  logic        r_a_inf;
  logic [9:0]  r_a_exp;
  logic [22:0] r_a_frac;
  logic        r_a_guard;
  logic        r_a_sticky;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_valid <= 1'b0;
    end else if (w_in_xfer) begin
      r_a_valid <= 1'b1;
    end else if (w_a_adv) begin
      r_a_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_a_s      <= 1'b0;
      r_a_zero   <= 1'b0;
      r_a_inf    <= 1'b0;
      r_a_exp    <= 10'd0;
      r_a_frac   <= 23'd0;
      r_a_guard  <= 1'b0;
      r_a_sticky <= 1'b0;
    end else if (w_in_xfer) begin
      r_a_s      <= in_s;
      r_a_zero   <= in_zero;
      r_a_inf    <= w_a_inf_nxt;
      r_a_exp    <= w_a_exp_nxt;
      r_a_frac   <= w_a_frac_nxt;
      r_a_guard  <= w_a_guard_nxt;
      r_a_sticky <= w_a_sticky_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Stage B: round to nearest even, then classify
  // --------------------------------------------------------------------------
  logic        w_inc;
  logic [23:0] w_sum;
  logic [9:0]  w_exp_fin;
  logic [22:0] w_frac_fin;
  logic [31:0] w_y;
  logic        w_ovf;
  logic        w_unf;

  // Round up above half, or at exactly half when the LSB is odd.
  assign w_inc      = r_a_guard & (r_a_sticky | r_a_frac[0]);
  assign w_sum      = {1'b0, r_a_frac} + {23'd0, w_inc};
  // A carry out of the fraction leaves frac = 0 (1.111.. + ulp = 10.000..).
  assign w_frac_fin = w_sum[22:0];
  assign w_exp_fin  = r_a_exp + {9'd0, w_sum[23]};

  always_comb begin
    w_y   = {r_a_s, w_exp_fin[7:0], w_frac_fin};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_a_zero) begin
      w_y = {r_a_s, 31'h0};
    end else if (r_a_inf || ($signed(w_exp_fin) >= $signed(c_EXP_MAX))) begin
      // NaN inputs land here too: they are not distinguished from infinity.
      w_y   = {r_a_s, 8'hFF, 23'h0};
      w_ovf = 1'b1;
    end else if ($signed(w_exp_fin) <= $signed(c_EXP_MIN)) begin
      // No denormal outputs: flush to signed zero.
      w_y   = {r_a_s, 31'h0};
      w_unf = 1'b1;
    end
  end

  logic [31:0] r_y;
  logic        r_ovf;
  logic        r_unf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_b_valid <= 1'b0;
    end else if (w_a_adv) begin
      r_b_valid <= 1'b1;
    end else if (out_ready) begin
      r_b_valid <= 1'b0;
    end
  end

  // Result registers only load on an advance, so they hold during a stall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_y   <= 32'h0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_a_adv) begin
      r_y   <= w_y;
      r_ovf <= w_ovf;
      r_unf <= w_unf;
    end
  end

  assign out_valid = r_b_valid;
  assign y         = r_y;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fmul_round.sv
`default_nettype none
// ============================================================================
// Module      : tb_fmul_round
// Description : Self-checking bench for fmul_round: directed vector table,
//               backpressure ordering sequence and asynchronous reset flush.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_round;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [7:0]  in_e1;
  logic [7:0]  in_e2;
  logic [47:0] in_prod;
  logic        in_zero;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        unf;

  fmul_round dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e1     (in_e1),
    .in_e2     (in_e2),
    .in_prod   (in_prod),
    .in_zero   (in_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .unf       (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [47:0] prod;
    logic        zero;
    logic [31:0] ey;
    logic        eovf;
    logic        eunf;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  int checks;
  int failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int i);
    in_s    = vt[i].s;
    in_e1   = vt[i].e1;
    in_e2   = vt[i].e2;
    in_prod = vt[i].prod;
    in_zero = vt[i].zero;
  endtask

  int order [4];
  int acc;

  initial begin
    checks   = 0;
    failures = 0;
    //          s   e1      e2      prod                  zero  y              ovf   unf
    vt[0]  = '{1'b0, 8'd127, 8'd127, 48'h9000_0000_0000, 1'b0, 32'h4010_0000, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 8'd127, 8'd127, 48'h4000_0040_0000, 1'b0, 32'h3F80_0000, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 8'd127, 8'd127, 48'h4000_00C0_0000, 1'b0, 32'h3F80_0002, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 8'd127, 8'd127, 48'h7FFF_FFC0_0000, 1'b0, 32'h4000_0000, 1'b0, 1'b0};
    vt[4]  = '{1'b1, 8'd254, 8'd254, 48'h4000_0000_0000, 1'b0, 32'hFF80_0000, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 8'd1,   8'd1,   48'h4000_0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 8'd255, 8'd127, 48'h4000_0000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 8'd128, 8'd128, 48'h6000_0000_0000, 1'b0, 32'h40C0_0000, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 8'd127, 8'd127, 48'h4000_0060_0000, 1'b0, 32'h3F80_0001, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 8'd127, 8'd127, 48'h4000_003F_FFFF, 1'b0, 32'h3F80_0000, 1'b0, 1'b0};
    vt[10] = '{1'b0, 8'd254, 8'd128, 48'h4000_0000_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0};
    vt[11] = '{1'b0, 8'd254, 8'd127, 48'h4000_0000_0000, 1'b0, 32'h7F00_0000, 1'b0, 1'b0};
    vt[12] = '{1'b0, 8'd254, 8'd127, 48'h8000_0000_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0};
    vt[13] = '{1'b0, 8'd254, 8'd127, 48'h7FFF_FFC0_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0};
    vt[14] = '{1'b0, 8'd64,  8'd64,  48'h4000_0000_0000, 1'b0, 32'h0080_0000, 1'b0, 1'b0};
    vt[15] = '{1'b0, 8'd63,  8'd64,  48'h4000_0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
    vt[16] = '{1'b0, 8'd63,  8'd64,  48'h8000_0000_0000, 1'b0, 32'h0080_0000, 1'b0, 1'b0};
    vt[17] = '{1'b0, 8'd63,  8'd64,  48'h7FFF_FFC0_0000, 1'b0, 32'h0080_0000, 1'b0, 1'b0};
    vt[18] = '{1'b0, 8'd255, 8'd1,   48'h4000_0000_0000, 1'b0, 32'h7F80_0000, 1'b1, 1'b0};
    vt[19] = '{1'b1, 8'd127, 8'd127, 48'h9000_0000_0000, 1'b0, 32'hC010_0000, 1'b0, 1'b0};
    vt[20] = '{1'b1, 8'd1,   8'd1,   48'h4000_0000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b1};

    // Reset state
    rstn      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(0);
    repeat (3) @(negedge clk);
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset y",         y,                  32'd0);
    chk("reset ovf",       {31'd0, ovf},       32'd0);
    chk("reset unf",       {31'd0, unf},       32'd0);
    chk("reset in_ready",  {31'd0, in_ready},  32'd1);
    rstn = 1'b1;

    // Directed table: one item at a time, latency checked on each
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(i);
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d early out_valid", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d y", i),         y,                  vt[i].ey);
      chk($sformatf("v%0d ovf", i),       {31'd0, ovf},       {31'd0, vt[i].eovf});
      chk($sformatf("v%0d unf", i),       {31'd0, unf},       {31'd0, vt[i].eunf});
    end
    @(negedge clk);
    #1;
    chk("drained out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: four back-to-back offers with the output stalled
    order[0] = 0;
    order[1] = 2;
    order[2] = 7;
    order[3] = 19;
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(order[acc]);
      in_valid = 1'b1;
      #1;
      if (c >= 2) begin
        chk($sformatf("bp stall%0d in_ready", c),  {31'd0, in_ready},  32'd0);
        chk($sformatf("bp stall%0d out_valid", c), {31'd0, out_valid}, 32'd1);
        chk($sformatf("bp stall%0d y", c),         y,                  vt[order[0]].ey);
      end
      if (in_ready) acc++;
    end
    chk("bp accepted while stalled", acc, 32'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (acc < 4) begin
        drive(order[acc]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk($sformatf("bp out%0d out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp out%0d y", k),         y,                  vt[order[k]].ey);
      if (in_valid && in_ready) acc++;
    end
    chk("bp accepted total", acc, 32'd4);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp drained out_valid", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset with two items in flight
    out_ready = 1'b0;
    @(negedge clk);
    drive(4);
    in_valid = 1'b1;
    @(negedge clk);
    drive(19);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("rst pre out_valid", {31'd0, out_valid}, 32'd1);
    chk("rst pre y",         y,                  vt[4].ey);
    chk("rst pre ovf",       {31'd0, ovf},       32'd1);
    #1;
    rstn = 1'b0;
    #1;
    chk("rst async out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst async y",         y,                  32'd0);
    chk("rst async ovf",       {31'd0, ovf},       32'd0);
    chk("rst async unf",       {31'd0, unf},       32'd0);
    @(negedge clk);
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("rst post%0d out_valid", c), {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fmul_round.md
# fmul_round

Normalise-and-round stage that sits directly downstream of the single-precision multiplier array in the FPU. It consumes the sign, the raw operand exponents and the 48-bit significand product produced by the multiplier stage. It then emits a packed IEEE-754 binary32 result with overflow and underflow flags. The stage is a two-register pipeline with a valid/ready handshake on both sides, so it can be stalled by the FPU writeback arbiter.

## Interface
Parameters: none.

- clk  input  1  clock; all registers rise-edge triggered
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  upstream offers an operand set this cycle
- in_ready  output  1  stage accepts the offered operand set this cycle
- in_s  input  1  result sign (already s1 XOR s2)
- in_e1, in_e2  input  8 each  raw biased exponents of the two operands
- in_prod  input  48  product of the two 24-bit significands, hidden bit included
- in_zero  input  1  either operand is zero or denormal (upstream decision)
- out_valid  output  1  y/ovf/unf hold a result
- out_ready  input  1  downstream consumes the result this cycle
- y  output  32  packed result {sign, exp[7:0], frac[22:0]}
- ovf  output  1  result overflowed to infinity
- unf  output  1  result underflowed and was flushed to zero

## Operation
- Transfers: a transfer occurs on any cycle where valid and ready are both high, checked on the rising edge of clk.
- Stage A register: captures on an input transfer.
  - exp10 = {2'b0,e1} + {2'b0,e2} - 127, as a 10-bit signed value.
  - If prod[47]=1: frac = prod[46:24], guard = prod[23], sticky = |prod[22:0], exp10 + 1.
  - Else: frac = prod[45:23], guard = prod[22], sticky = |prod[21:0].
  - Also captures s, zero, and inf_in = (e1==255)|(e2==255).
- Stage B register: rounds to nearest, ties to even.
  - inc = guard & (sticky | frac[0]).
  - frac+inc carrying out of bit 22 gives frac = 0 and exp + 1.
- Stage B classification, in priority order:
  - zero: y = {s,31'h0}, ovf = 0, unf = 0.
  - inf_in or final exp >= 255: y = {s,8'hFF,23'h0}, ovf = 1.
  - final exp <= 0: y = {s,31'h0}, unf = 1. No denormal output.
  - Otherwise: y = {s,exp[7:0],frac}.
- NaN operands are not distinguished; they follow the inf_in path.

## Timing
- Reset values: out_valid = 0, y = 32'h0, ovf = 0, unf = 0. Both internal valid bits are 0.
- Reset mid-operation discards every in-flight item. Nothing is output after rstn releases until new input is accepted.
- Latency: 2 cycles from the input transfer edge to out_valid high, when unstalled.
- Throughput: 1 result per cycle.
- Stall logic:
  - b_free = ~B_valid | out_ready.
  - A advances into B when A_valid & b_free.
  - in_ready = ~A_valid | b_free. This is a combinational path from out_ready to in_ready.
- While out_valid & ~out_ready, y, ovf and unf hold stable.
- Simultaneous output transfer and A→B advance in one cycle is legal and loses no item.
- in_* may change freely when in_valid = 0. They are sampled only on a transfer.
- The stage holds at most 2 items. With out_ready low, in_ready falls after the second item is accepted.

## Test plan
- 1.5×1.5: in_e1 = in_e2 = 127, in_prod = 48'h9000_0000_0000, s = 0 -> y = 32'h4010_0000, ovf = unf = 0, two cycles after the input transfer.
- Rounding ties, both with e1 = e2 = 127:
  - in_prod = 48'h4000_0040_0000 (tie, even) -> y = 32'h3F80_0000.
  - in_prod = 48'h4000_00C0_0000 (tie, odd) -> y = 32'h3F80_0002.
- Mantissa carry: e1 = e2 = 127, in_prod = 48'h7FFF_FFC0_0000 -> y = 32'h4000_0000.
- Special cases:
  - e1 = e2 = 254, in_prod = 48'h4000_0000_0000, s = 1 -> y = 32'hFF80_0000, ovf = 1.
  - e1 = e2 = 1 -> y = 0, unf = 1.
  - in_zero = 1 with e1 = 255 -> y = {s,31'h0}, no flags.
- Backpressure: issue 4 back-to-back inputs with out_ready = 0.
  - Exactly 2 are accepted, then in_ready = 0 and out_valid holds the first result unchanged.
  - Raise out_ready: all 4 results emerge in order on consecutive cycles.
- Reset: assert rstn low asynchronously with 2 items in flight -> out_valid, y, ovf and unf read 0 immediately (before the next clk edge). No stale result appears after release.
